sync_memory: RTL and testbench

- Single-port, synchronous read/write memory of 2**ADDR_WIDTH words × DATA_WIDTH bits.
- Used as the leaf storage block behind the memory verification interface (intf).
- Writes commit on the rising clock edge.
- Reads return registered data one cycle after the request, with a valid strobe.

---
 rtl/sync_memory.sv | 132 +++++++++++++
 tb/tb_sync_memory.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sync_memory.sv
// -----------------------------------------------------------------------------
// sync_memory
//   Single-port synchronous read/write memory, 2**ADDR_WIDTH x DATA_WIDTH.
//   Writes commit on the rising edge. Reads are registered: the data appears
//   one cycle after the request, together with a one-cycle valid strobe.
//   When a read and a write hit the same cycle, the read returns the old
//   contents (read-first) and the write still commits.
//
//   Optional feature macro: SYNC_MEMORY_PARITY_EN
//     Each word also stores an even-parity bit. A read reports parity_err
//     when the stored bit disagrees with the parity of the stored data.
//     The data is returned unmodified.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = in reset)
//   addr       in   word address for the read and/or write
//   wr_en      in   write enable (unknown values are treated as 0)
//   rd_en      in   read enable (unknown values are treated as 0)
//   wdata      in   write data
//   parity_err out  parity mismatch on the returned word (parity build only)
//   rdata      out  registered read data
//   rd_valid   out  high for the cycle rdata carries a fresh read result
// -----------------------------------------------------------------------------
module sync_memory #(
    parameter int                    ADDR_WIDTH  = 2,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef SYNC_MEMORY_PARITY_EN
    output logic                  parity_err,
`endif
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;
    logic                  wr_s;
    logic                  rd_s;

`ifdef SYNC_MEMORY_PARITY_EN
    logic                  par_q [DEPTH];
    logic                  par_d [DEPTH];
    logic                  parity_err_q;
    logic                  parity_err_d;
`endif

    // Enables count only when they are a definite 1, so X/Z never writes.
    always_comb begin
        wr_s = (wr_en === 1'b1);
        rd_s = (rd_en === 1'b1);
    end

    // Next-state for storage and the read register (read uses old contents).
    always_comb begin
        mem_d      = mem_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
`ifdef SYNC_MEMORY_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        if (wr_s) begin
            mem_d[addr] = wdata;
`ifdef SYNC_MEMORY_PARITY_EN
            par_d[addr] = even_parity(wdata);
`endif
        end else begin
            mem_d[addr] = mem_q[addr];
        end
        if (rd_s) begin
            rdata_d    = mem_q[addr];
            rd_valid_d = 1'b1;
`ifdef SYNC_MEMORY_PARITY_EN
            parity_err_d = (par_q[addr] != even_parity(mem_q[addr]));
`endif
        end else begin
            rdata_d    = rdata_q;
            rd_valid_d = 1'b0;
        end
    end

    // State registers; reset clears every location without needing a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VALUE;
`ifdef SYNC_MEMORY_PARITY_EN
                par_q[i] <= even_parity(RESET_VALUE);
`endif
            end
            rdata_q    <= RESET_VALUE;
            rd_valid_q <= 1'b0;
`ifdef SYNC_MEMORY_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            mem_q      <= mem_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
`ifdef SYNC_MEMORY_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
`ifdef SYNC_MEMORY_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sync_memory.sv
// -----------------------------------------------------------------------------
// tb_sync_memory
//   Directed, self-checking bench for sync_memory (default parameters:
//   4 words x 8 bits, reset value 0). Inputs change 1 time unit after a
//   rising edge and outputs are sampled at that same point, i.e. well away
//   from the active edge. Parity steps are built only when
//   SYNC_MEMORY_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_sync_memory;

    logic       clk;
    logic       reset;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rd_valid;
`ifdef SYNC_MEMORY_PARITY_EN
    logic       parity_err;
`endif

    int n_vec;
    int n_err;

    sync_memory #(
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
`ifdef SYNC_MEMORY_PARITY_EN
        .parity_err(parity_err),
`endif
        .rdata     (rdata),
        .rd_valid  (rd_valid)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr  = a;
        rd_en = 1'b1;
        wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
        check({tag, "_data"}, {24'h0, rdata}, {24'h0, exp});
        check({tag, "_valid"}, {31'h0, rd_valid}, 32'h1);
    endtask

    logic [7:0] exp_rd [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        addr  = 2'd0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;

        // 1. Reset: held for two cycles, outputs at reset values throughout.
        tick();
        check("rst_valid_c1", {31'h0, rd_valid}, 32'h0);
        rd_en = 1'b1;  // must be ignored while in reset
        tick();
        check("rst_valid_c2", {31'h0, rd_valid}, 32'h0);
        check("rst_rdata", {24'h0, rdata}, 32'h0);
        rd_en = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_read($sformatf("rst_rd%0d", i), 2'(i), 8'h00);
        end
        tick();
        check("idle_valid", {31'h0, rd_valid}, 32'h0);

        // 2. Write then read back all four locations.
        exp_rd[0] = 8'hA5;
        exp_rd[1] = 8'h3C;
        exp_rd[2] = 8'hFF;
        exp_rd[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            do_write(2'(i), exp_rd[i]);
        end
        check("wr_no_valid", {31'h0, rd_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            do_read($sformatf("wr_rd%0d", i), 2'(i), exp_rd[i]);
        end

        // 4. Hold: after reading 0x3C, idle cycles keep rdata and drop valid.
        do_read("hold_rd", 2'd1, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            addr = 2'(i);  // address must be ignored when idle
            tick();
            check($sformatf("hold_data%0d", i), {24'h0, rdata}, 32'h3C);
            check($sformatf("hold_valid%0d", i), {31'h0, rd_valid}, 32'h0);
        end

        // 3. Read-first collision on addr 2.
        do_write(2'd2, 8'h11);
        addr  = 2'd2;
        wdata = 8'h22;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("coll_old", {24'h0, rdata}, 32'h11);
        check("coll_valid", {31'h0, rd_valid}, 32'h1);
        do_read("coll_new", 2'd2, 8'h22);

        // Back-to-back reads every cycle.
        addr  = 2'd0;
        rd_en = 1'b1;
        tick();
        check("b2b_0", {24'h0, rdata}, 32'hA5);
        addr = 2'd3;
        tick();
        check("b2b_3", {24'h0, rdata}, 32'h01);
        check("b2b_valid", {31'h0, rd_valid}, 32'h1);
        rd_en = 1'b0;

        // 5. Async reset mid-stream with a read in flight.
        do_write(2'd1, 8'h77);
        addr  = 2'd1;
        rd_en = 1'b1;
        tick();
        check("pre_rst_data", {24'h0, rdata}, 32'h77);
        #2;  // between edges, with another read requested
        reset = 1'b0;
        #1;
        check("async_data", {24'h0, rdata}, 32'h0);
        check("async_valid", {31'h0, rd_valid}, 32'h0);
        tick();
        check("async_hold_valid", {31'h0, rd_valid}, 32'h0);
        rd_en = 1'b0;
        reset = 1'b1;
        do_read("post_rst_a1", 2'd1, 8'h00);
        do_read("post_rst_a2", 2'd2, 8'h00);

`ifdef SYNC_MEMORY_PARITY_EN
        // 6. Parity: clean readback, then a corrupted parity bit.
        do_write(2'd0, 8'h5A);
        do_read("par_clean", 2'd0, 8'h5A);
        check("par_clean_err", {31'h0, parity_err}, 32'h0);
        dut.par_q[0] = ~dut.par_q[0];
        do_read("par_bad", 2'd0, 8'h5A);
        check("par_bad_err", {31'h0, parity_err}, 32'h1);
        tick();
        check("par_idle_err", {31'h0, parity_err}, 32'h0);
        do_write(2'd3, 8'h07);
        do_read("par_odd", 2'd3, 8'h07);
        check("par_odd_err", {31'h0, parity_err}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
